// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter and receiver.
//   IDLE/START/DATA/STOP : one-hot FSM state encodings
//   uart_state_t         : state register type
//   cnt_width()          : counter width helper, never returns less than 1
package uart_pkg;

  typedef logic [3:0] uart_state_t;

  localparam uart_state_t IDLE  = 4'b0001;
  localparam uart_state_t START = 4'b0010;
  localparam uart_state_t DATA  = 4'b0100;
  localparam uart_state_t STOP  = 4'b1000;

  // Bits needed to hold 0..n-1, with a floor of one bit so degenerate
  // parameterisations still produce legal vectors.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- two-flop synchronizer for the asynchronous serial line,
// plus a falling-edge detector on the synchronized value.
//   clk_i   : receiver clock
//   rst_ni  : asynchronous active-low reset (all flops reset to 1 = idle line)
//   rx_i    : raw asynchronous serial input
//   rx_s_o  : synchronized serial line
//   fall_o  : high for one cycle when rx_s_o goes 1 -> 0
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_s_o = rx_s_q;
  assign fall_o = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1-style UART receiver with FIFO write interface.
//   clk_in       : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   rx           : asynchronous serial line, idle high
//   fifo_full_in : downstream FIFO full flag, sampled at the stop bit
//   data_out     : last successfully received word (registered)
//   rx_wr_en     : one-cycle write strobe qualifying data_out
//   frame_err    : one-cycle pulse, stop bit sampled low
//   overrun      : one-cycle pulse, good frame dropped because FIFO full
// Optional build macro UART_RX_MAJORITY_EN: every bit decision is a 2-of-3
// majority over the sample point and its two neighbours, decided one cycle
// after the plain single-sample point.
// Assumes DATA_WIDTH >= 2 and BIT_CYC >= 3.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  fifo_full_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rx_wr_en,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int BIT_CYC  = CLK_FREQUENCE / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = cnt_width(BIT_CYC);
  localparam int BIT_W    = cnt_width(DATA_WIDTH);

  // Decision counts. With majority voting the start decision moves one
  // count later; the data/stop periods keep their length, so every later
  // window is centred on the same absolute cycle as the single-sample build.
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC = HALF_CYC;
`else
  localparam int START_DEC = HALF_CYC - 1;
`endif
  localparam int BIT_DEC = BIT_CYC - 1;

  localparam logic [CNT_W-1:0] START_DEC_C = CNT_W'(START_DEC);
  localparam logic [CNT_W-1:0] BIT_DEC_C   = CNT_W'(BIT_DEC);
  localparam logic [BIT_W-1:0] LAST_BIT_C  = BIT_W'(DATA_WIDTH - 1);

  logic rx_s;
  logic rx_fall;
  logic smp;

  uart_rx_sync u_sync (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous synchronized samples; together with rx_s they form the
  // three-sample voting window ending at the decision cycle.
  logic [1:0] hist_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s};
  end

  assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign smp = rx_s;
`endif

  uart_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  fe_q, fe_d;
  logic                  ov_q, ov_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_fall) state_d = START;
      end
      START: begin
        if (cnt_q == START_DEC_C) begin
          cnt_d   = '0;
          // A line back high at mid start bit was a glitch, not a frame.
          state_d = smp ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_DEC_C) begin
          cnt_d   = '0;
          shift_d = {smp, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_BIT_C) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_DEC_C) begin
          // Leave at mid stop bit so the next start edge is caught on time.
          cnt_d   = '0;
          state_d = IDLE;
          if (!smp) begin
            fe_d = 1'b1;
          end else if (fifo_full_in) begin
            ov_d = 1'b1;
          end else begin
            wr_d   = 1'b1;
            data_d = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data_out  = data_q;
  assign rx_wr_en  = wr_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLK_F  = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BITC   = CLK_F / BAUD;

  logic       clk_in;
  logic       rst_n;
  logic       rx;
  logic       fifo_full_in;
  logic [7:0] data_out;
  logic       rx_wr_en;
  logic       frame_err;
  logic       overrun;

  int tests_run;
  int tests_failed;

  uart_rx #(
    .CLK_FREQUENCE (CLK_F),
    .BAUD_RATE     (BAUD),
    .DATA_WIDTH    (8)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .rx           (rx),
    .fifo_full_in (fifo_full_in),
    .data_out     (data_out),
    .rx_wr_en     (rx_wr_en),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Event log, sampled on the falling edge away from the active edge.
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         fe_tot;
  int         ov_tot;
  int         excl_tot;
  int         cyc;

  initial begin
    fe_tot = 0; ov_tot = 0; excl_tot = 0; cyc = 0;
  end

  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (rx_wr_en) begin
        wr_data.push_back(data_out);
        wr_cyc.push_back(cyc);
      end
      if (frame_err) fe_tot <= fe_tot + 1;
      if (overrun)   ov_tot <= ov_tot + 1;
      if (int'(rx_wr_en) + int'(frame_err) + int'(overrun) > 1) excl_tot <= excl_tot + 1;
    end
  end

  // Serial line waveform: start bit, LSB-first data, stop bit, each BITC cycles.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    rx = 1'b0;
    repeat (BITC) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BITC) @(negedge clk_in);
    end
    rx = stop_ok;
    repeat (BITC) @(negedge clk_in);
    rx = 1'b1;
  endtask

  logic [7:0] last_written;  // model of data_out

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; fifo_full_in = 1'b0;
    repeat (3) @(negedge clk_in);
    tests_run++;
    if ({data_out, rx_wr_en, frame_err, overrun} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%0h wr=%0b fe=%0b ov=%0b expected all 0",
               data_out, rx_wr_en, frame_err, overrun);
    end
    rst_n = 1'b1;
    last_written = 8'h00;
    repeat (20) @(negedge clk_in);
    tests_run++;
    if (wr_data.size() != 0 || fe_tot != 0 || ov_tot != 0) begin
      tests_failed++;
      $display("FAIL reset_idle: got wr=%0d fe=%0d ov=%0d expected 0 0 0",
               wr_data.size(), fe_tot, ov_tot);
    end
  endtask

  task automatic test_single();
    int w0 = wr_data.size(); int f0 = fe_tot; int o0 = ov_tot;
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk_in);
    last_written = 8'h55;
    tests_run++;
    if (wr_data.size() - w0 != 1 || fe_tot != f0 || ov_tot != o0) begin
      tests_failed++;
      $display("FAIL single_counts: got wr=%0d fe=%0d ov=%0d expected 1 0 0",
               wr_data.size() - w0, fe_tot - f0, ov_tot - o0);
    end else begin
      tests_run++;
      if (wr_data[w0] !== 8'h55) begin
        tests_failed++;
        $display("FAIL single_data: got %0h expected 55", wr_data[w0]);
      end
    end
    tests_run++;
    if (data_out !== 8'h55) begin
      tests_failed++;
      $display("FAIL single_hold: got %0h expected 55", data_out);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_data.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (20) @(negedge clk_in);
    last_written = 8'h0F;
    tests_run++;
    if (wr_data.size() - w0 != 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d expected 2", wr_data.size() - w0);
    end else begin
      tests_run++;
      if (wr_data[w0] !== 8'hA3 || wr_data[w0+1] !== 8'h0F) begin
        tests_failed++;
        $display("FAIL b2b_data: got %0h %0h expected a3 0f", wr_data[w0], wr_data[w0+1]);
      end
      tests_run++;
      if (wr_cyc[w0+1] - wr_cyc[w0] != 10 * BITC) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d expected %0d", wr_cyc[w0+1] - wr_cyc[w0], 10 * BITC);
      end
    end
  endtask

  task automatic test_frame_err();
    int w0 = wr_data.size(); int f0 = fe_tot; int o0 = ov_tot;
    send_frame(8'hFF, 1'b0);
    repeat (20) @(negedge clk_in);
    tests_run++;
    if (fe_tot - f0 != 1 || wr_data.size() != w0 || ov_tot != o0) begin
      tests_failed++;
      $display("FAIL frame_err_counts: got fe=%0d wr=%0d ov=%0d expected 1 0 0",
               fe_tot - f0, wr_data.size() - w0, ov_tot - o0);
    end
    tests_run++;
    if (data_out !== last_written) begin
      tests_failed++;
      $display("FAIL frame_err_hold: got %0h expected %0h", data_out, last_written);
    end
  endtask

  task automatic test_glitch();
    int w0 = wr_data.size(); int f0 = fe_tot; int o0 = ov_tot;
    rx = 1'b0;
    repeat (3) @(negedge clk_in);
    rx = 1'b1;
    repeat (15 * BITC) @(negedge clk_in);
    tests_run++;
    if (wr_data.size() != w0 || fe_tot != f0 || ov_tot != o0) begin
      tests_failed++;
      $display("FAIL glitch_quiet: got wr=%0d fe=%0d ov=%0d expected 0 0 0",
               wr_data.size() - w0, fe_tot - f0, ov_tot - o0);
    end
    send_frame(8'hC6, 1'b1);
    repeat (20) @(negedge clk_in);
    last_written = 8'hC6;
    tests_run++;
    if (wr_data.size() - w0 != 1 || data_out !== 8'hC6) begin
      tests_failed++;
      $display("FAIL glitch_recover: got wr=%0d data=%0h expected 1 c6",
               wr_data.size() - w0, data_out);
    end
  endtask

  task automatic test_overrun();
    int w0 = wr_data.size(); int f0 = fe_tot; int o0 = ov_tot;
    fifo_full_in = 1'b1;
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk_in);
    tests_run++;
    if (ov_tot - o0 != 1 || wr_data.size() != w0 || fe_tot != f0) begin
      tests_failed++;
      $display("FAIL overrun_counts: got ov=%0d wr=%0d fe=%0d expected 1 0 0",
               ov_tot - o0, wr_data.size() - w0, fe_tot - f0);
    end
    tests_run++;
    if (data_out !== last_written) begin
      tests_failed++;
      $display("FAIL overrun_hold: got %0h expected %0h", data_out, last_written);
    end
    fifo_full_in = 1'b0;
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk_in);
    last_written = 8'h3C;
    tests_run++;
    if (wr_data.size() - w0 != 1 || data_out !== 8'h3C || ov_tot - o0 != 1) begin
      tests_failed++;
      $display("FAIL overrun_after: got wr=%0d data=%0h ov=%0d expected 1 3c 1",
               wr_data.size() - w0, data_out, ov_tot - o0);
    end
  endtask

  // Random frames against a rule-level model: good stop and room -> write,
  // good stop and full -> overrun, bad stop -> frame error.
  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] d;
      bit stop_ok, full;
      int exp_wr, exp_fe, exp_ov;
      int w0 = wr_data.size(); int f0 = fe_tot; int o0 = ov_tot;
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      full    = ($urandom_range(0, 3) == 0);
      exp_wr  = (stop_ok && !full) ? 1 : 0;
      exp_ov  = (stop_ok && full) ? 1 : 0;
      exp_fe  = stop_ok ? 0 : 1;
      fifo_full_in = full;
      send_frame(d, stop_ok);
      repeat (5 + $urandom_range(0, 20)) @(negedge clk_in);
      fifo_full_in = 1'b0;
      if (exp_wr == 1) last_written = d;
      tests_run++;
      if (wr_data.size() - w0 != exp_wr || fe_tot - f0 != exp_fe || ov_tot - o0 != exp_ov) begin
        tests_failed++;
        $display("FAIL rand_counts[%0d] d=%0h: got wr=%0d fe=%0d ov=%0d expected %0d %0d %0d",
                 n, d, wr_data.size() - w0, fe_tot - f0, ov_tot - o0, exp_wr, exp_fe, exp_ov);
      end
      tests_run++;
      if (data_out !== last_written) begin
        tests_failed++;
        $display("FAIL rand_data[%0d]: got %0h expected %0h", n, data_out, last_written);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    rx = 1'b0;
    repeat (BITC) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BITC) @(negedge clk_in);
    end
    repeat (BITC / 2) @(negedge clk_in);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    tests_run++;
    if ({data_out, rx_wr_en, frame_err, overrun} !== 11'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got data=%0h wr=%0b fe=%0b ov=%0b expected all 0",
               data_out, rx_wr_en, frame_err, overrun);
    end
    repeat (4) @(negedge clk_in);
    rst_n = 1'b1;
    last_written = 8'h00;
    w0 = wr_data.size();
    repeat (12 * BITC) @(negedge clk_in);
    tests_run++;
    if (wr_data.size() != w0 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_no_resume: got wr=%0d data=%0h expected 0 0",
               wr_data.size() - w0, data_out);
    end
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk_in);
    tests_run++;
    if (wr_data.size() - w0 != 1 || data_out !== 8'h81) begin
      tests_failed++;
      $display("FAIL midreset_fresh: got wr=%0d data=%0h expected 1 81",
               wr_data.size() - w0, data_out);
    end
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (excl_tot != 0) begin
      tests_failed++;
      $display("FAIL exclusive: got %0d overlapping cycles expected 0", excl_tot);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    rx = 1'b1;
    fifo_full_in = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_random();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQUENCE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate; BIT_CYC = CLK_FREQUENCE/BAUD_RATE (integer division), HALF_CYC = BIT_CYC/2.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port fifo_full_in  input  1  downstream FIFO full flag.
REQ-008 SHALL have port data_out  output  DATA_WIDTH  last received word, registered.
REQ-009 SHALL have port rx_wr_en  output  1  one-cycle FIFO write strobe, qualifies data_out.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse, good frame dropped because FIFO full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1); the FSM sees only the synchronized signal rx_s.
REQ-013 SHALL implement a one-hot FSM: IDLE, START, DATA, STOP.
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0), SHALL clear the baud counter and go to START; otherwise stay.
REQ-015 START: when the baud counter reaches HALF_CYC-1, SHALL sample rx_s; 1 -> false start, return to IDLE with no output; 0 -> clear counter, go to DATA.
REQ-016 DATA: each time the counter reaches BIT_CYC-1, SHALL sample rx_s and shift it in LSB-first, clearing the counter; after DATA_WIDTH samples -> STOP.
REQ-017 STOP: at counter BIT_CYC-1, SHALL sample rx_s and return to IDLE in the same transition, allowing a back-to-back start edge to be detected half a bit later.
REQ-018 Stop sample 1 and fifo_full_in 0: SHALL load data_out and assert rx_wr_en for exactly one cycle, on the cycle after the stop sample.
REQ-019 Stop sample 1 and fifo_full_in 1: SHALL assert overrun for one cycle; rx_wr_en and data_out are unchanged.
REQ-020 Stop sample 0: SHALL assert frame_err for one cycle; no write; data_out unchanged.
REQ-021 The baud counter SHALL count only outside IDLE, be ceil(log2(BIT_CYC)) bits wide, and never exceed BIT_CYC-1.
REQ-022 rx_wr_en, frame_err and overrun SHALL be mutually exclusive in any cycle.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, counters 0, shift register 0, data_out 0, rx_wr_en 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait for a fresh falling edge and not resume the old frame.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN defined: each START/DATA/STOP sample SHALL be the 2-of-3 majority of rx_s at counter values target-1, target and target+1, with the decision taken at target+1; all state timing shifts one cycle later accordingly.
REQ-026 Macro undefined: single sample at the target count (REQ-015 to REQ-017), with no majority logic synthesized.

Structure
REQ-027 A shared package uart_pkg SHALL hold the one-hot state localparams (IDLE 4'b0001, START 4'b0010, DATA 4'b0100, STOP 4'b1000), shared by uart_tx and uart_rx.
REQ-028 A single sub-module, uart_rx_sync (parameterless 2-flop synchronizer with falling-edge detect output), is natural; all other logic SHALL live in uart_rx.

Verification (CLK_FREQUENCE=1_000_000, BAUD_RATE=100_000, so BIT_CYC=10, DATA_WIDTH=8, FIFO not full unless stated)
REQ-029 Send frame 0x55 with a good stop bit -> exactly one rx_wr_en pulse, data_out=0x55, no frame_err or overrun.
REQ-030 Send 0xA3 then 0x0F back-to-back (no idle gap) -> two rx_wr_en pulses, data_out 0xA3 then 0x0F, pulses 100 cycles apart.
REQ-031 Send 0xFF with the stop bit held low -> frame_err pulses once, no rx_wr_en, data_out keeps its previous value.
REQ-032 Drive a 3-cycle low glitch on idle rx -> false start, return to IDLE, no output pulse of any kind.
REQ-033 Hold fifo_full_in=1 and send 0x3C -> overrun pulses once, no rx_wr_en; after fifo_full_in falls, send 0x3C again -> rx_wr_en, data_out=0x3C.
REQ-034 Assert rst_n low during bit 4 of a frame, then release and send 0x81 -> only 0x81 is written; all outputs read 0 during reset.
